// File: rtl/console_uart_mux.sv
// console_uart_mux: shares one UART between the hexbus debug port and a
// 7-bit console. Received bytes are split by bit 7 (1 = hexbus, 0 = console).
// Outgoing characters are arbitrated so a hexbus word (terminated by a
// newline or by a bus-idle timeout) is never split by console traffic.
//
// Handshake: a source raises *_stb with *_data and holds both stable until a
// cycle in which the matching *_busy output is 0; that cycle is the transfer.
// The UART side transfers o_tx_data in any cycle with o_tx_stb && !i_tx_busy.
// Received-side strobes (o_hb_stb, o_con_stb) are single-cycle with no
// back-pressure.
module console_uart_mux #(
  parameter int LGIDLE = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_con_stb,
  input  logic [6:0] i_con_data,
  output logic       o_con_busy,
  output logic       o_con_stb,
  output logic [6:0] o_con_data,
  input  logic       i_hb_stb,
  input  logic [6:0] i_hb_data,
  output logic       o_hb_busy,
  output logic       o_hb_stb,
  output logic [6:0] o_hb_data,
  output logic       o_tx_stb,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_busy,
  input  logic       i_rx_stb,
  input  logic [7:0] i_rx_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_CON  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LGIDLE-1:0] idle_cnt_q, idle_cnt_d;
  logic              tx_stb_q;
  logic [7:0]        tx_data_q;
  logic              hb_stb_q, con_stb_q;
  logic [6:0]        hb_data_q, con_data_q;

  logic              load;
  logic              hb_accept, con_accept;
  logic              idle_done;
  logic              hb_newline;

  // The output register can take a new byte when empty or when the UART is
  // consuming the current one this cycle.
  assign load       = !tx_stb_q || !i_tx_busy;
  assign idle_done  = &idle_cnt_q;
  assign hb_newline = (i_hb_data == 7'h0a);

  // Arbiter next state, idle counter and per-source accept decisions.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    hb_accept  = 1'b0;
    con_accept = 1'b0;
    case (state_q)
      S_IDLE: begin
        idle_cnt_d = '0;
        if (load && i_hb_stb) begin
          hb_accept = 1'b1;
          // A lone newline is a complete word; no need to hold the bus.
          if (!hb_newline) state_d = S_BUS;
        end else if (load && i_con_stb) begin
          con_accept = 1'b1;
          state_d    = S_CON;
        end
      end
      S_BUS: begin
        if (load && i_hb_stb) begin
          hb_accept  = 1'b1;
          idle_cnt_d = '0;
          if (hb_newline) state_d = S_IDLE;
        end else if (idle_done) begin
          // Word abandoned: counter stays saturated until IDLE clears it.
          state_d = S_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + LGIDLE'(1);
        end
      end
      S_CON: begin
        // The console grant covers exactly the one char taken on entry.
        idle_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: begin
        idle_cnt_d = '0;
        state_d    = S_IDLE;
      end
    endcase
    // Nothing is accepted while reset is asserted, so no source loses a char.
    if (i_reset) begin
      hb_accept  = 1'b0;
      con_accept = 1'b0;
    end
  end

  // Arbiter state and idle counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Transmit valid: refreshed on every load, cleared by reset (drops held byte).
  always_ff @(posedge i_clk) begin
    if (i_reset) tx_stb_q <= 1'b0;
    else if (load) tx_stb_q <= hb_accept || con_accept;
  end

  // Transmit data: tagged with bit 7 so the far end can demultiplex.
  always_ff @(posedge i_clk) begin
    if (load) begin
      if (hb_accept) tx_data_q <= {1'b1, i_hb_data};
      else if (con_accept) tx_data_q <= {1'b0, i_con_data};
    end
  end

  // Receive strobes: one-cycle pulses routed by the received bit 7.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hb_stb_q  <= 1'b0;
      con_stb_q <= 1'b0;
    end else begin
      hb_stb_q  <= i_rx_stb && i_rx_data[7];
      con_stb_q <= i_rx_stb && !i_rx_data[7];
    end
  end

  // Receive data: each side keeps its last char between strobes.
  always_ff @(posedge i_clk) begin
    if (i_rx_stb && i_rx_data[7]) hb_data_q <= i_rx_data[6:0];
    if (i_rx_stb && !i_rx_data[7]) con_data_q <= i_rx_data[6:0];
  end

  assign o_hb_busy  = !hb_accept;
  assign o_con_busy = !con_accept;
  assign o_tx_stb   = tx_stb_q;
  assign o_tx_data  = tx_data_q;
  assign o_hb_stb   = hb_stb_q;
  assign o_hb_data  = hb_data_q;
  assign o_con_stb  = con_stb_q;
  assign o_con_data = con_data_q;

endmodule

// File: tb/tb_console_uart_mux.sv
// tb_console_uart_mux: directed scenarios followed by randomized traffic.
// A word-level reference model (is a hexbus word open, how long has it been
// silent, which bytes are waiting for the UART) predicts every busy output,
// the UART byte stream and the receive strobes each cycle.
module tb_console_uart_mux;
  localparam int LGIDLE  = 4;
  localparam int TIMEOUT = 1 << LGIDLE;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_con_stb;
  logic [6:0] i_con_data;
  logic       o_con_busy;
  logic       o_con_stb;
  logic [6:0] o_con_data;
  logic       i_hb_stb;
  logic [6:0] i_hb_data;
  logic       o_hb_busy;
  logic       o_hb_stb;
  logic [6:0] o_hb_data;
  logic       o_tx_stb;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;
  logic       i_rx_stb;
  logic [7:0] i_rx_data;

  console_uart_mux #(.LGIDLE(LGIDLE)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_con_stb(i_con_stb), .i_con_data(i_con_data), .o_con_busy(o_con_busy),
    .o_con_stb(o_con_stb), .o_con_data(o_con_data),
    .i_hb_stb(i_hb_stb), .i_hb_data(i_hb_data), .o_hb_busy(o_hb_busy),
    .o_hb_stb(o_hb_stb), .o_hb_data(o_hb_data),
    .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
    .i_rx_stb(i_rx_stb), .i_rx_data(i_rx_data)
  );

  // Clock / watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  int total = 0;
  int bad   = 0;

  // Bench-side sources: pending chars and whether the head is presented.
  logic [6:0] hb_q[$];
  logic [6:0] con_q[$];
  bit         hb_vld = 1'b0;
  bit         con_vld = 1'b0;
  int         p_hb = 100, p_con = 100, tx_busy_pct = 0;

  // Reference model and scoreboard.
  logic [7:0] exp_q[$];   // accepted bytes not yet taken by the UART
  bit         m_word;     // a hexbus word holds the link
  int         m_silent;   // clocks since the last hexbus char in the word
  bit         m_gap;      // a granted console char occupies the arbiter one clock
  bit         m_rx_stb;
  logic [7:0] m_rx_data;
  logic [7:0] tx_log[$];  // bytes the UART actually took
  bit         chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present source heads, randomize UART busy, clear rx strobe.
  task automatic drive();
    if (!hb_vld && hb_q.size() != 0 && $urandom_range(0, 99) < p_hb) hb_vld = 1'b1;
    if (!con_vld && con_q.size() != 0 && $urandom_range(0, 99) < p_con) con_vld = 1'b1;
    i_hb_stb  = hb_vld;
    i_con_stb = con_vld;
    if (hb_vld) i_hb_data = hb_q[0];
    if (con_vld) i_con_data = con_q[0];
    i_tx_busy = ($urandom_range(0, 99) < tx_busy_pct);
    i_rx_stb  = 1'b0;
  endtask

  // One clock: check at the falling edge, advance the model, drive after the rise.
  task automatic step();
    bit ld, hb_acc, con_acc;
    @(negedge i_clk);
    ld      = (exp_q.size() == 0) || !i_tx_busy;
    hb_acc  = 1'b0;
    con_acc = 1'b0;
    if (!i_reset) begin
      if (m_word) begin
        hb_acc = ld && i_hb_stb;
      end else if (!m_gap) begin
        hb_acc  = ld && i_hb_stb;
        con_acc = ld && i_con_stb && !i_hb_stb;
      end
    end
    if (chk_en) begin
      chk("hb_busy", o_hb_busy, !hb_acc);
      chk("con_busy", o_con_busy, !con_acc);
      chk("tx_stb", o_tx_stb, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("tx_data", o_tx_data, exp_q[0]);
      chk("rx_hb_stb", o_hb_stb, m_rx_stb && m_rx_data[7]);
      chk("rx_con_stb", o_con_stb, m_rx_stb && !m_rx_data[7]);
      if (m_rx_stb && m_rx_data[7]) chk("rx_hb_data", o_hb_data, m_rx_data[6:0]);
      else if (m_rx_stb) chk("rx_con_data", o_con_data, m_rx_data[6:0]);
      if (o_tx_stb === 1'b1 && !i_tx_busy) tx_log.push_back(o_tx_data);
    end
    if (i_reset) begin
      exp_q.delete();
      m_word   = 1'b0;
      m_silent = 0;
      m_gap    = 1'b0;
      m_rx_stb = 1'b0;
    end else begin
      if (exp_q.size() != 0 && !i_tx_busy) void'(exp_q.pop_front());
      if (hb_acc) exp_q.push_back({1'b1, i_hb_data});
      if (con_acc) exp_q.push_back({1'b0, i_con_data});
      m_gap = con_acc;
      if (hb_acc) begin
        m_silent = 0;
        m_word   = (i_hb_data != 7'h0a);
      end else if (m_word) begin
        m_silent++;
        if (m_silent >= TIMEOUT) m_word = 1'b0;
      end
      m_rx_stb  = i_rx_stb;
      m_rx_data = i_rx_data;
    end
    if (hb_acc) begin void'(hb_q.pop_front()); hb_vld = 1'b0; end
    if (con_acc) begin void'(con_q.pop_front()); con_vld = 1'b0; end
    @(posedge i_clk);
    #1;
    drive();
  endtask

  // Run until all source chars reached the UART, bounded.
  task automatic drain(input string tag, input int bound);
    int n = 0;
    bit pending;
    pending = 1'b1;
    while (pending && n < bound) begin
      step();
      n++;
      pending = hb_q.size() != 0 || con_q.size() != 0 || hb_vld || con_vld || exp_q.size() != 0;
    end
    chk({tag, "_drain_pending"}, pending, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_word[7];
    int con_early;
    int n;
    exp_word = '{8'hD2, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h8A, 8'h58};

    // Reset
    i_reset = 1'b1; i_hb_stb = 1'b0; i_hb_data = '0; i_con_stb = 1'b0; i_con_data = '0;
    i_tx_busy = 1'b0; i_rx_stb = 1'b0; i_rx_data = '0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_tx_stb", o_tx_stb, 1'b0);
    chk("rst_hb_stb", o_hb_stb, 1'b0);
    chk("rst_con_stb", o_con_stb, 1'b0);
    i_reset = 1'b0;

    // Receive demux
    i_rx_stb = 1'b1; i_rx_data = 8'hC1;
    step();
    chk("demux_hb_stb", o_hb_stb, 1'b1);
    chk("demux_hb_data", o_hb_data, 7'h41);
    chk("demux_con_stb_lo", o_con_stb, 1'b0);
    i_rx_stb = 1'b1; i_rx_data = 8'h41;
    step();
    chk("demux_con_stb", o_con_stb, 1'b1);
    chk("demux_con_data", o_con_data, 7'h41);
    chk("demux_hb_stb_single", o_hb_stb, 1'b0);
    step();
    chk("demux_con_stb_single", o_con_stb, 1'b0);

    // Word integrity: "R1234\n" with console 'X' held throughout
    tx_log.delete();
    hb_q = '{7'h52, 7'h31, 7'h32, 7'h33, 7'h34, 7'h0a};
    con_q = '{7'h58};
    drive();
    con_early = 0;
    n = 0;
    #1;
    while ((hb_q.size() != 0 || con_q.size() != 0 || exp_q.size() != 0) && n < 60) begin
      if (hb_q.size() != 0 && o_con_busy !== 1'b1) con_early++;
      step();
      #1;
      n++;
    end
    chk("word_con_busy_in_word", con_early, 0);
    chk("word_log_len", tx_log.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("word_byte%0d", i), (i < tx_log.size()) ? {24'd0, tx_log[i]} : 32'hxxxxxxxx,
          {24'd0, exp_word[i]});

    // Back-pressure: UART busy for 10 clocks while holding 'R'
    hb_q = '{7'h52, 7'h35, 7'h0a};
    con_q = '{7'h41};
    tx_busy_pct = 0;
    drive();
    step();
    tx_busy_pct = 100;
    i_tx_busy = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_tx_stb", o_tx_stb, 1'b1);
      chk("bp_tx_data", o_tx_data, 8'hD2);
      chk("bp_hb_busy", o_hb_busy, 1'b1);
      chk("bp_con_busy", o_con_busy, 1'b1);
      step();
      #1;
    end
    tx_busy_pct = 0;
    i_tx_busy = 1'b0;
    drain("bp", 60);

    // Idle timeout: 'R' then silence; console waits exactly 2^LGIDLE clocks
    tx_log.delete();
    hb_q = '{7'h52};
    con_q = '{7'h58};
    drive();
    step();
    n = 0;
    #1;
    while (o_con_busy === 1'b1 && n < 40) begin
      step();
      #1;
      n++;
    end
    chk("timeout_clocks", n, TIMEOUT);
    drain("timeout", 60);
    chk("timeout_log_len", tx_log.size(), 2);
    chk("timeout_con_byte", (tx_log.size() == 2) ? {24'd0, tx_log[1]} : 32'hxxxxxxxx, 32'h58);

    // Priority: both strobe in IDLE, hexbus wins
    tx_log.delete();
    hb_q = '{7'h41, 7'h0a};
    con_q = '{7'h43};
    drive();
    #1;
    chk("prio_hb_accept", o_hb_busy, 1'b0);
    chk("prio_con_wait", o_con_busy, 1'b1);
    drain("prio", 60);
    chk("prio_log_len", tx_log.size(), 3);
    chk("prio_first", (tx_log.size() > 0) ? {24'd0, tx_log[0]} : 32'hxxxxxxxx, 32'hC1);
    chk("prio_con_last", (tx_log.size() > 2) ? {24'd0, tx_log[2]} : 32'hxxxxxxxx, 32'h43);

    // Reset mid-word with a byte held in the output register
    tx_log.delete();
    hb_q = '{7'h52, 7'h31, 7'h32};
    con_q = '{7'h58};
    drive();
    step();
    step();
    tx_busy_pct = 100;
    i_tx_busy = 1'b1;
    hb_q.delete();
    hb_vld = 1'b0;
    i_hb_stb = 1'b0;
    #1;
    chk("rstw_held_before", o_tx_stb, 1'b1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    tx_busy_pct = 0;
    i_tx_busy = 1'b0;
    #1;
    chk("rstw_tx_stb", o_tx_stb, 1'b0);
    chk("rstw_con_accept", o_con_busy, 1'b0);
    drain("rstw", 40);
    chk("rstw_log_len", tx_log.size(), 2);
    chk("rstw_con_byte", (tx_log.size() == 2) ? {24'd0, tx_log[1]} : 32'hxxxxxxxx, 32'h58);

    // Randomized traffic
    p_hb = 60; p_con = 40; tx_busy_pct = 30;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (hb_q.size() == 0) begin
        int nd, d;
        hb_q.push_back(7'h52);
        nd = $urandom_range(0, 4);
        for (int k = 0; k < nd; k++) begin
          d = $urandom_range(0, 15);
          hb_q.push_back((d < 10) ? 7'(8'h30 + d) : 7'(8'h61 + d - 10));
        end
        if ($urandom_range(0, 99) < 80) hb_q.push_back(7'h0a);
      end
      if (con_q.size() == 0) con_q.push_back(7'($urandom_range(0, 127)));
      if ($urandom_range(0, 99) < 30) begin
        i_rx_stb  = 1'b1;
        i_rx_data = 8'($urandom_range(0, 255));
      end
      i_reset = (cyc == 400);
      step();
      i_reset = 1'b0;
    end
    p_hb = 100; p_con = 100; tx_busy_pct = 0;
    drain("rand", 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
